// File: rtl/cell_read_scheduler.sv
// -----------------------------------------------------------------------------
// cell_read_scheduler
//
// Per-output-port dequeue scheduler for the shared cell buffer. Each output
// queue is a linked list in the buffer; this block keeps the head pointer and
// cell count of every queue, picks one ready, non-empty queue per cycle,
// drives the buffer read, and follows the list by capturing the next-cell
// pointer the buffer returns one cycle after each read.
//
// Build option:
//   SCHED_STRICT_PRIO_EN  defined   -> fixed priority, lowest eligible port wins
//                         undefined -> round-robin starting after the last grant
//
// Ports:
//   clk          clock, all state on rising edge
//   rst          synchronous active-high reset
//   enq_valid    accepted buffer write linked to queue enq_port this cycle
//   enq_port     destination queue of the enqueued cell
//   enq_addr     buffer address of the enqueued cell
//   port_ready   bit p: output p can accept a cell
//   rd_en        buffer read enable (combinational, zero-cycle grant)
//   rd_addr      buffer read address = head of the granted queue
//   next_ptr     next-cell pointer from the buffer, valid the cycle after rd_en
//   cell_valid   buffer read data valid (registered rd_en)
//   cell_port    output port owning the current read data
//   queue_empty  bit p: queue p holds no cells
// -----------------------------------------------------------------------------
module cell_read_scheduler #(
  parameter int nbrOfPorts   = 4,
  parameter int addresses    = 32,
  parameter int addressWidth = $clog2(addresses)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          enq_valid,
  input  logic [$clog2(nbrOfPorts)-1:0] enq_port,
  input  logic [addressWidth-1:0]       enq_addr,
  input  logic [nbrOfPorts-1:0]         port_ready,
  output logic                          rd_en,
  output logic [addressWidth-1:0]       rd_addr,
  input  logic [addressWidth-1:0]       next_ptr,
  output logic                          cell_valid,
  output logic [$clog2(nbrOfPorts)-1:0] cell_port,
  output logic [nbrOfPorts-1:0]         queue_empty
);

  localparam int PW = $clog2(nbrOfPorts);
  localparam int CW = $clog2(addresses + 1);
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};

  // EMPTY: no cells; ARMED: cells queued, head valid; PTR_WAIT: head was just
  // read and its successor pointer is arriving on next_ptr this cycle.
  typedef enum logic [1:0] {
    Q_EMPTY    = 2'd0,
    Q_ARMED    = 2'd1,
    Q_PTR_WAIT = 2'd2
  } q_state_e;

  q_state_e                st_q        [nbrOfPorts];
  q_state_e                st_d        [nbrOfPorts];
  logic [addressWidth-1:0] head_q      [nbrOfPorts];
  logic [addressWidth-1:0] head_d      [nbrOfPorts];
  logic [CW-1:0]           count_q     [nbrOfPorts];
  logic [CW-1:0]           count_d     [nbrOfPorts];
  logic [addressWidth-1:0] byp_addr_q  [nbrOfPorts];
  logic [addressWidth-1:0] byp_addr_d  [nbrOfPorts];
  logic [nbrOfPorts-1:0]   byp_valid_q;
  logic [nbrOfPorts-1:0]   byp_valid_d;

  logic                    cell_valid_q;
  logic [PW-1:0]           cell_port_q;

  logic [nbrOfPorts-1:0]   elig_s;
  logic [nbrOfPorts-1:0]   gnt_vec_s;
  logic [nbrOfPorts-1:0]   enq_vec_s;
  logic                    gnt_any_s;
  logic [PW-1:0]           gnt_port_s;

  // Eligibility, per-port grant/enqueue decode and empty flags.
  always_comb begin
    for (int p = 0; p < nbrOfPorts; p++) begin
      elig_s[p]      = port_ready[p] & (st_q[p] == Q_ARMED);
      gnt_vec_s[p]   = rd_en & (gnt_port_s == PW'(p));
      enq_vec_s[p]   = enq_valid & (enq_port == PW'(p));
      queue_empty[p] = (count_q[p] == CNT_ZERO);
    end
  end

`ifdef SCHED_STRICT_PRIO_EN
  // Fixed priority: scanning downwards lets the lowest eligible index win.
  always_comb begin
    gnt_any_s  = 1'b0;
    gnt_port_s = {PW{1'b0}};
    for (int i = nbrOfPorts - 1; i >= 0; i--) begin
      gnt_any_s  = gnt_any_s | elig_s[i];
      gnt_port_s = elig_s[i] ? PW'(i) : gnt_port_s;
    end
  end
`else
  logic [PW-1:0] rr_last_q;

  // Round-robin: candidates rr_last+1 .. rr_last+N (mod N, power of two).
  // Scanning from the farthest candidate back lets the nearest one win.
  always_comb begin
    gnt_any_s  = 1'b0;
    gnt_port_s = {PW{1'b0}};
    for (int k = nbrOfPorts; k >= 1; k--) begin
      gnt_any_s  = gnt_any_s | elig_s[rr_last_q + PW'(k)];
      gnt_port_s = elig_s[rr_last_q + PW'(k)] ? (rr_last_q + PW'(k)) : gnt_port_s;
    end
  end

  // Round-robin pointer: remembers the most recently granted port.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_last_q <= PW'(nbrOfPorts - 1);
    end else if (gnt_any_s) begin
      rr_last_q <= gnt_port_s;
    end else begin
      rr_last_q <= rr_last_q;
    end
  end
`endif

  // Buffer read port; grants are suppressed while reset is asserted.
  assign rd_en   = gnt_any_s & ~rst;
  assign rd_addr = rd_en ? head_q[gnt_port_s] : {addressWidth{1'b0}};

  // Per-queue next state: pointer follow, count update, bypass capture.
  always_comb begin
    for (int p = 0; p < nbrOfPorts; p++) begin
      head_d[p]      = head_q[p];
      count_d[p]     = count_q[p];
      byp_valid_d[p] = byp_valid_q[p];
      byp_addr_d[p]  = byp_addr_q[p];
      st_d[p]        = st_q[p];

      // Successor of the cell read last cycle: a cell linked while its
      // predecessor was being read wins over the stale next_ptr.
      if (st_q[p] == Q_PTR_WAIT) begin
        if (byp_valid_q[p]) begin
          head_d[p]      = byp_addr_q[p];
          byp_valid_d[p] = 1'b0;
        end else if (count_q[p] != CNT_ZERO) begin
          head_d[p] = next_ptr;
        end else begin
          head_d[p] = head_q[p];
        end
      end else begin
        head_d[p] = head_q[p];
      end

      if (gnt_vec_s[p]) begin
        if (enq_vec_s[p]) begin
          // Read and enqueue cancel; if the read drains the last cell, the
          // new cell's address is not yet in next_ptr, so keep it aside.
          count_d[p] = count_q[p];
          if (count_q[p] == CNT_ONE) begin
            byp_valid_d[p] = 1'b1;
            byp_addr_d[p]  = enq_addr;
          end else begin
            byp_valid_d[p] = byp_valid_q[p];
          end
        end else begin
          count_d[p] = count_q[p] - CNT_ONE;
        end
      end else if (enq_vec_s[p]) begin
        count_d[p] = count_q[p] + CNT_ONE;
        // Empty queue (idle or waiting on a drained pointer): new cell is head.
        head_d[p]  = (count_q[p] == CNT_ZERO) ? enq_addr : head_d[p];
      end else begin
        count_d[p] = count_q[p];
      end

      if (gnt_vec_s[p]) begin
        st_d[p] = Q_PTR_WAIT;
      end else if (count_d[p] == CNT_ZERO) begin
        st_d[p] = Q_EMPTY;
      end else begin
        st_d[p] = Q_ARMED;
      end
    end
  end

  // Per-queue state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int p = 0; p < nbrOfPorts; p++) begin
        st_q[p]       <= Q_EMPTY;
        head_q[p]     <= {addressWidth{1'b0}};
        count_q[p]    <= CNT_ZERO;
        byp_addr_q[p] <= {addressWidth{1'b0}};
      end
      byp_valid_q <= {nbrOfPorts{1'b0}};
    end else begin
      for (int p = 0; p < nbrOfPorts; p++) begin
        st_q[p]       <= st_d[p];
        head_q[p]     <= head_d[p];
        count_q[p]    <= count_d[p];
        byp_addr_q[p] <= byp_addr_d[p];
      end
      byp_valid_q <= byp_valid_d;
    end
  end

  // Read-data qualifiers, aligned with the buffer's one-cycle read latency.
  always_ff @(posedge clk) begin
    if (rst) begin
      cell_valid_q <= 1'b0;
      cell_port_q  <= {PW{1'b0}};
    end else if (rd_en) begin
      cell_valid_q <= 1'b1;
      cell_port_q  <= gnt_port_s;
    end else begin
      cell_valid_q <= 1'b0;
      cell_port_q  <= cell_port_q;
    end
  end

  assign cell_valid = cell_valid_q;
  assign cell_port  = cell_port_q;

endmodule

// File: tb/tb_cell_read_scheduler.sv
// -----------------------------------------------------------------------------
// Bench for cell_read_scheduler: a table of directed cycles, hand-written
// corner sequences, and randomized traffic checked against a FIFO-per-port
// reference model that also plays the role of the buffer's link memory.
// -----------------------------------------------------------------------------
module tb_cell_read_scheduler;

  localparam int NP = 4;
  localparam int NA = 32;
  localparam int AW = 5;
  localparam int PW = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          enq_valid = 1'b0;
  logic [PW-1:0] enq_port = '0;
  logic [AW-1:0] enq_addr = '0;
  logic [NP-1:0] port_ready = '0;
  logic [AW-1:0] next_ptr = '0;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic          cell_valid;
  logic [PW-1:0] cell_port;
  logic [NP-1:0] queue_empty;

  always #5 clk = ~clk;

  cell_read_scheduler #(.nbrOfPorts(NP), .addresses(NA)) dut (
    .clk(clk), .rst(rst), .enq_valid(enq_valid), .enq_port(enq_port),
    .enq_addr(enq_addr), .port_ready(port_ready), .rd_en(rd_en),
    .rd_addr(rd_addr), .next_ptr(next_ptr), .cell_valid(cell_valid),
    .cell_port(cell_port), .queue_empty(queue_empty)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int mq [NP][$];          // cell addresses per queue, head first
  bit busy [NP];           // queue was read last cycle
  int rr_last;
  bit exp_cv;
  int exp_cport;
  int next_mem [NA];       // link memory as the buffer holds it
  bit last_en;
  int last_addr;
  int free_list [$];
  bit pf_v;
  int pf_a;
  bit obs_en;
  int obs_addr;

  function automatic void model_reset();
    for (int p = 0; p < NP; p++) begin
      mq[p].delete();
      busy[p] = 1'b0;
    end
    rr_last   = NP - 1;
    exp_cv    = 1'b0;
    exp_cport = 0;
    last_en   = 1'b0;
    last_addr = 0;
    pf_v      = 1'b0;
    free_list.delete();
    for (int a = 0; a < NA; a++) begin
      free_list.push_back(a);
      next_mem[a] = a ^ 31;
    end
  endfunction

  function automatic bit elig(input int p, input logic [NP-1:0] rdy);
    return rdy[p] && (mq[p].size() > 0) && !busy[p];
  endfunction

  task automatic step(input bit ev, input int ep, input int ea, input logic [NP-1:0] rdy);
    bit ge;
    int g;
    int c;
    logic [NP-1:0] eqe;
    if (pf_v) begin
      free_list.push_back(pf_a);
      pf_v = 1'b0;
    end
    @(negedge clk);
    enq_valid  = ev;
    enq_port   = PW'(ep);
    enq_addr   = AW'(ea);
    port_ready = rdy;
    next_ptr   = last_en ? AW'(next_mem[last_addr]) : AW'($urandom);
    #1;
    ge = 1'b0;
    g  = 0;
`ifdef SCHED_STRICT_PRIO_EN
    for (int p = 0; p < NP; p++) begin
      if (!ge && elig(p, rdy)) begin
        ge = 1'b1;
        g  = p;
      end
    end
`else
    for (int k = 1; k <= NP; k++) begin
      c = (rr_last + k) % NP;
      if (!ge && elig(c, rdy)) begin
        ge = 1'b1;
        g  = c;
      end
    end
`endif
    obs_en   = rd_en;
    obs_addr = int'(rd_addr);
    chk("rd_en", int'(rd_en), int'(ge));
    if (ge) chk("rd_addr", int'(rd_addr), mq[g][0]);
    chk("cell_valid", int'(cell_valid), int'(exp_cv));
    if (exp_cv) chk("cell_port", int'(cell_port), exp_cport);
    for (int p = 0; p < NP; p++) eqe[p] = (mq[p].size() == 0);
    chk("queue_empty", int'(queue_empty), int'(eqe));
    // advance model across the rising edge
    for (int p = 0; p < NP; p++) busy[p] = 1'b0;
    last_en = ge;
    exp_cv  = ge;
    if (ge) begin
      last_addr = mq[g][0];
      pf_v      = 1'b1;
      pf_a      = last_addr;
      void'(mq[g].pop_front());
      busy[g]   = 1'b1;
      rr_last   = g;
      exp_cport = g;
    end
    if (ev) begin
      if (mq[ep].size() > 0) next_mem[mq[ep][$]] = ea;
      mq[ep].push_back(ea);
      next_mem[ea] = ea ^ 31;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst        = 1'b1;
    enq_valid  = 1'b0;
    port_ready = '1;
    #1;
    chk("rst_cycle_rd_en", int'(rd_en), 0);
    @(negedge clk);
    #1;
    chk("rst_cell_valid", int'(cell_valid), 0);
    chk("rst_queue_empty", int'(queue_empty), 15);
    chk("rst_rd_en", int'(rd_en), 0);
    chk("rst_rd_addr", int'(rd_addr), 0);
    rst = 1'b0;
    model_reset();
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    bit ev; int ep; int ea; logic [3:0] rdy; int np;
    bit en; int addr; bit cv; int cp; logic [3:0] qe;
  } vec_t;

  vec_t vecs [$];
  int   alt_seq [8] = '{0, 10, 1, 11, 2, 12, 3, 13};

  function automatic vec_t mk(bit ev, int ep, int ea, logic [3:0] rdy, int np,
                              bit en, int addr, bit cv, int cp, logic [3:0] qe);
    vec_t v;
    v.ev = ev; v.ep = ep; v.ea = ea; v.rdy = rdy; v.np = np;
    v.en = en; v.addr = addr; v.cv = cv; v.cp = cp; v.qe = qe;
    return v;
  endfunction

  initial begin
    // list 5 -> 9 -> 2 on port 1, then a single cell on empty port 0
    vecs.push_back(mk(1, 1, 5, 4'b0010,  0, 0, 0, 0, 0, 4'b1111));
    vecs.push_back(mk(1, 1, 9, 4'b0010,  0, 1, 5, 0, 0, 4'b1101));
    vecs.push_back(mk(1, 1, 2, 4'b0010,  9, 0, 0, 1, 1, 4'b1101));
    vecs.push_back(mk(0, 0, 0, 4'b0010,  0, 1, 9, 0, 0, 4'b1101));
    vecs.push_back(mk(0, 0, 0, 4'b0010,  2, 0, 0, 1, 1, 4'b1101));
    vecs.push_back(mk(0, 0, 0, 4'b0010,  0, 1, 2, 0, 0, 4'b1101));
    vecs.push_back(mk(0, 0, 0, 4'b0010, 17, 0, 0, 1, 1, 4'b1111));
    vecs.push_back(mk(0, 0, 0, 4'b0010,  0, 0, 0, 0, 0, 4'b1111));
    vecs.push_back(mk(1, 0, 4, 4'b0001,  0, 0, 0, 0, 0, 4'b1111));
    vecs.push_back(mk(0, 0, 0, 4'b0001,  0, 1, 4, 0, 0, 4'b1110));
    vecs.push_back(mk(0, 0, 0, 4'b0001, 23, 0, 0, 1, 0, 4'b1111));

    do_reset();
    foreach (vecs[i]) begin
      @(negedge clk);
      enq_valid  = vecs[i].ev;
      enq_port   = PW'(vecs[i].ep);
      enq_addr   = AW'(vecs[i].ea);
      port_ready = vecs[i].rdy;
      next_ptr   = AW'(vecs[i].np);
      #1;
      chk("tv_rd_en", int'(rd_en), int'(vecs[i].en));
      if (vecs[i].en) chk("tv_rd_addr", int'(rd_addr), vecs[i].addr);
      chk("tv_cell_valid", int'(cell_valid), int'(vecs[i].cv));
      if (vecs[i].cv) chk("tv_cell_port", int'(cell_port), vecs[i].cp);
      chk("tv_queue_empty", int'(queue_empty), int'(vecs[i].qe));
    end

    // ports 0 and 2 with four cells each: back-to-back alternation
    do_reset();
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 0, i, 4'b0000);
      step(1'b1, 2, 10 + i, 4'b0000);
    end
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 0, 0, 4'b0101);
      chk("alt_rd_en", int'(obs_en), 1);
      chk("alt_rd_addr", obs_addr, alt_seq[i]);
    end

    // last cell read while the next one is linked: bypass, not next_ptr
    do_reset();
    step(1'b1, 3, 7, 4'b0000);
    step(1'b1, 3, 12, 4'b1000);
    chk("byp_first_addr", obs_addr, 7);
    step(1'b0, 0, 0, 4'b1000);
    chk("byp_wait_rd_en", int'(obs_en), 0);
    chk("byp_count_kept", int'(queue_empty[3]), 0);
    step(1'b0, 0, 0, 4'b1000);
    chk("byp_second_en", int'(obs_en), 1);
    chk("byp_second_addr", obs_addr, 12);

    // port 2 held off by port_ready while port 1 drains
    do_reset();
    step(1'b1, 2, 20, 4'b0000);
    step(1'b1, 2, 21, 4'b0000);
    step(1'b1, 2, 22, 4'b0000);
    step(1'b1, 1, 25, 4'b0000);
    step(1'b1, 1, 26, 4'b0000);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 0, 0, 4'b0010);
      chk("ready_gate", int'(obs_en && obs_addr >= 20 && obs_addr <= 22), 0);
    end
    step(1'b0, 0, 0, 4'b0110);
    chk("ready_resume", obs_addr, 20);
    for (int i = 0; i < 5; i++) step(1'b0, 0, 0, 4'b0110);

    // reset in the cycle after a grant, with another port eligible
    do_reset();
    step(1'b1, 0, 3, 4'b0000);
    step(1'b1, 0, 6, 4'b0000);
    step(1'b1, 1, 8, 4'b0000);
    step(1'b0, 0, 0, 4'b0001);
    chk("pre_rst_grant", obs_addr, 3);
    do_reset();
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 0, 0, 4'b1111);
      chk("post_rst_rd_en", int'(obs_en), 0);
    end

    // randomized traffic against the model, with one reset in the middle
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      bit ev;
      int ep;
      int ea;
      int idx;
      if (i == 1500) do_reset();
      ev = (free_list.size() > 0) && ($urandom_range(2, 0) != 0);
      ep = $urandom_range(NP - 1, 0);
      ea = 0;
      if (ev) begin
        idx = $urandom_range(free_list.size() - 1, 0);
        ea  = free_list[idx];
        free_list.delete(idx);
      end
      step(ev, ep, ea, NP'($urandom) | (($urandom_range(3, 0) == 0) ? 4'hF : 4'h0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
